// File: rtl/regfile_scoreboard_if.sv
// Register-file/scoreboard bus: two read ports, one issue port and one writeback port.
// The master drives addresses and strobes; the slave (register file) returns data and busy flags.
interface regfile_scoreboard_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_s1;
  logic [ADDR_W-1:0] rd_addr_s2;
  logic [DATA_W-1:0] rd_data_s1;
  logic [DATA_W-1:0] rd_data_s2;
  logic              busy_s1;
  logic              busy_s2;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr_d;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr_d;
  logic [DATA_W-1:0] w_data_d;
  logic              wb_err;

  modport master (
    output rd_addr_s1, rd_addr_s2, iss_en, iss_addr_d, w_en, w_addr_d, w_data_d,
    input  rd_data_s1, rd_data_s2, busy_s1, busy_s2, wb_err
  );

  modport slave (
    input  rd_addr_s1, rd_addr_s2, iss_en, iss_addr_d, w_en, w_addr_d, w_data_d,
    output rd_data_s1, rd_data_s2, busy_s1, busy_s2, wb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits and a sticky bad-writeback flag.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data/busy onto the read ports.
module regfile_scoreboard #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 5,
  parameter int unsigned       SP_IDX  = 29,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h80028000)
) (
  input logic                  clock,
  input logic                  reset,
  regfile_scoreboard_if.slave  bus_io
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] mem_d [Depth];
  logic [Depth-1:0]  pend_q, pend_d;
  logic              wb_err_q, wb_err_d;

  logic              wr_ok, iss_ok;

  assign wr_ok  = bus_io.w_en   && (bus_io.w_addr_d   != '0);
  assign iss_ok = bus_io.iss_en && (bus_io.iss_addr_d != '0);

  always_comb begin
    mem_d    = mem_q;
    pend_d   = pend_q;
    wb_err_d = wb_err_q;
    if (wr_ok) begin
      mem_d[bus_io.w_addr_d]  = bus_io.w_data_d;
      pend_d[bus_io.w_addr_d] = 1'b0;
      if (!pend_q[bus_io.w_addr_d]) begin
        wb_err_d = 1'b1;
      end
    end
    // Issue applied after writeback so a same-address collision leaves the bit set.
    if (iss_ok) begin
      pend_d[bus_io.iss_addr_d] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < Depth; k++) begin
        mem_q[k] <= (k == SP_IDX) ? SP_INIT : DATA_W'(k);
      end
      pend_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      pend_q   <= pend_d;
      wb_err_q <= wb_err_d;
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  assign rd_addr[0] = bus_io.rd_addr_s1;
  assign rd_addr[1] = bus_io.rd_addr_s2;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rd_data[i] = mem_q[rd_addr[i]];
      rd_busy[i] = pend_q[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
      if (!reset && wr_ok && (bus_io.w_addr_d == rd_addr[i])) begin
        rd_data[i] = bus_io.w_data_d;
        rd_busy[i] = iss_ok && (bus_io.iss_addr_d == rd_addr[i]);
      end
`endif
      if (rd_addr[i] == '0) begin
        rd_data[i] = '0;
        rd_busy[i] = 1'b0;
      end
    end
  end

  assign bus_io.rd_data_s1 = rd_data[0];
  assign bus_io.rd_data_s2 = rd_data[1];
  assign bus_io.busy_s1    = rd_busy[0];
  assign bus_io.busy_s2    = rd_busy[1];
  assign bus_io.wb_err     = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed corner cases then random traffic,
// with expected read-port values produced by an array-based reference model.
module tb_regfile_scoreboard;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned N  = 1 << AW;
  localparam int unsigned SP = 29;
  localparam logic [DW-1:0] SPV = 32'h80028000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_scoreboard #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .SP_IDX (SP),
    .SP_INIT(SPV)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus_io(bus)
  );

  typedef struct {
    logic [DW-1:0] d1;
    logic          b1;
    logic [DW-1:0] d2;
    logic          b2;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];

  logic [DW-1:0] ref_mem [N];
  logic          ref_pend [N];
  logic          ref_err;

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;
  logic drv_done = 1'b0;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      ref_mem[k]  = (k == SP) ? SPV : DW'(k);
      ref_pend[k] = 1'b0;
    end
    ref_err = 1'b0;
  endtask

  task automatic model_read(input logic [AW-1:0] a, input logic rst, input logic iss,
                            input logic [AW-1:0] ia, input logic w, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, output logic [DW-1:0] d, output logic b);
    d = ref_mem[a];
    b = ref_pend[a];
`ifdef REGFILE_BYPASS_EN
    if (!rst && w && wa == a) begin
      d = wd;
      b = iss && (ia == a);
    end
`endif
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end
  endtask

  // One clock of stimulus: drive, record expected pre-edge outputs, then advance the model.
  task automatic do_cycle(input logic rst, input logic iss, input logic [AW-1:0] ia,
                          input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    exp_t e;
    @(negedge clock);
    reset          = rst;
    bus.iss_en     = iss;
    bus.iss_addr_d = ia;
    bus.w_en       = w;
    bus.w_addr_d   = wa;
    bus.w_data_d   = wd;
    bus.rd_addr_s1 = r1;
    bus.rd_addr_s2 = r2;
    if (rst) model_reset();
    model_read(r1, rst, iss, ia, w, wa, wd, e.d1, e.b1);
    model_read(r2, rst, iss, ia, w, wa, wd, e.d2, e.b2);
    e.err = ref_err;
    e.cyc = cyc_no;
    exp_q.push_back(e);
    cyc_no++;
    if (!rst) begin
      if (w && wa != 0) begin
        if (!ref_pend[wa]) ref_err = 1'b1;
        ref_mem[wa]  = wd;
        ref_pend[wa] = 1'b0;
      end
      if (iss && ia != 0) ref_pend[ia] = 1'b1;
    end
  endtask

  task automatic idle_read(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    do_cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, r1, r2);
  endtask

  // Monitor: samples the read ports mid-cycle and compares against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 5;
        if (bus.rd_data_s1 !== e.d1) begin
          errors++;
          $display("FAIL rd_data_s1 cycle %0d: got %h expected %h", e.cyc, bus.rd_data_s1, e.d1);
        end
        if (bus.busy_s1 !== e.b1) begin
          errors++;
          $display("FAIL busy_s1 cycle %0d: got %b expected %b", e.cyc, bus.busy_s1, e.b1);
        end
        if (bus.rd_data_s2 !== e.d2) begin
          errors++;
          $display("FAIL rd_data_s2 cycle %0d: got %h expected %h", e.cyc, bus.rd_data_s2, e.d2);
        end
        if (bus.busy_s2 !== e.b2) begin
          errors++;
          $display("FAIL busy_s2 cycle %0d: got %b expected %b", e.cyc, bus.busy_s2, e.b2);
        end
        if (bus.wb_err !== e.err) begin
          errors++;
          $display("FAIL wb_err cycle %0d: got %b expected %b", e.cyc, bus.wb_err, e.err);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] ia, wa, r1, r2;
    logic [DW-1:0] wd;
    logic          iss, w, rst;
    int            guard;

    bus.iss_en = 1'b0; bus.iss_addr_d = '0;
    bus.w_en = 1'b0; bus.w_addr_d = '0; bus.w_data_d = '0;
    bus.rd_addr_s1 = '0; bus.rd_addr_s2 = '0;
    model_reset();

    do_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 5'd29, 5'd7);
    idle_read(5'd29, 5'd7);
    idle_read(5'd31, 5'd0);

    do_cycle(1'b0, 1'b1, 5'd5, 1'b0, '0, '0, 5'd5, 5'd1);
    idle_read(5'd5, 5'd5);
    do_cycle(1'b0, 1'b0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6);
    idle_read(5'd5, 5'd5);

    do_cycle(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    idle_read(5'd0, 5'd0);

    do_cycle(1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h1234, 5'd9, 5'd9);
    idle_read(5'd9, 5'd9);
    do_cycle(1'b0, 1'b0, '0, 1'b1, 5'd9, 32'h55, 5'd9, 5'd2);
    idle_read(5'd9, 5'd9);

    do_cycle(1'b0, 1'b1, 5'd3, 1'b0, '0, '0, 5'd1, 5'd3);
    do_cycle(1'b0, 1'b1, 5'd4, 1'b1, 5'd3, 32'hA5A5, 5'd4, 5'd3);
    idle_read(5'd4, 5'd3);

    do_cycle(1'b0, 1'b0, '0, 1'b1, 5'd12, 32'hCAFE, 5'd12, 5'd0);
    idle_read(5'd12, 5'd4);
    idle_read(5'd12, 5'd29);
    do_cycle(1'b1, 1'b1, 5'd12, 1'b1, 5'd12, 32'h77, 5'd12, 5'd29);
    idle_read(5'd12, 5'd4);

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      iss = ($urandom_range(0, 2) == 0);
      w   = ($urandom_range(0, 1) == 0);
      ia  = AW'($urandom_range(0, 7));
      wa  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, N - 1))
                                         : AW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) ia = wa;
      wd  = $urandom();
      r1  = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7));
      r2  = ($urandom_range(0, 2) == 0) ? ia : AW'($urandom_range(0, N - 1));
      do_cycle(rst, iss, ia, w, wa, wd, r1, r2);
    end
    idle_read(5'd1, 5'd2);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    #5;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
